// File: rtl/idex_pkg.sv
// Shared definitions for the ID/EX stage: datapath width, ALU op codes,
// operand-select encodings and the skid-buffer state type.
package idex_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;

    localparam logic [1:0] BSEL_RS2 = 2'b00;
    localparam logic [1:0] BSEL_IMM = 2'b01;
    localparam logic [1:0] BSEL_4   = 2'b10;
    localparam logic [1:0] BSEL_0   = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

    // x0 is hardwired to zero, so a write to it is never architecturally visible.
    function automatic logic rd_write_en(input logic wen, input logic [4:0] rd);
        return wen && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/idex_skid_buf.sv
// Generic 2-entry valid/ready buffer with a registered in_ready and a
// synchronous flush; payload width and reset value are parameters.
module idex_skid_buf #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import idex_pkg::*;

    skid_state_t  state, state_nxt;
    logic [W-1:0] head_p1, skid_p1;
    logic         in_xfer, out_xfer;
    logic         head_load, head_from_skid, skid_load;

    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = head_p1;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = SKID_ONE;
                    head_load = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_load = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = SKID_FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the drain path exists
                if (out_xfer) begin
                    state_nxt      = SKID_ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
        if (flush) begin
            state_nxt      = SKID_EMPTY;
            head_load      = 1'b0;
            head_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SKID_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != SKID_FULL);
        end
    end

    // Entry storage: head feeds the consumer, skid catches the one extra beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_p1 <= RESET_VAL;
            skid_p1 <= '0;
        end else begin
            if (head_load) begin
                head_p1 <= in_data;
            end else if (head_from_skid) begin
                head_p1 <= skid_p1;
            end
            if (skid_load) begin
                skid_p1 <= in_data;
            end
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX stage: operand select, rd_wen masking and optional writeback bypass
// (macro IDEX_BYPASS_EN) in front of a 2-entry skid buffer.
module idex_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alua_sel,
    input  logic [1:0]      in_alub_sel,
    input  logic [3:0]      in_aluctr,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
`ifdef IDEX_BYPASS_EN
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alua,
    output logic [XLEN-1:0] out_alub,
    output logic [3:0]      out_aluctr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen
);
    import idex_pkg::*;

    localparam int PW = 4 * XLEN + 4 + 5 + 1;
    localparam logic [PW-1:0] PAYLOAD_RESET =
        {{XLEN{1'b0}}, {XLEN{1'b0}}, 4'b0000, PC_RESET, {XLEN{1'b0}}, 5'd0, 1'b0};

    function automatic logic [XLEN-1:0] sel_a(input logic sel,
                                               input logic [XLEN-1:0] rs1,
                                               input logic [XLEN-1:0] pc);
        return (sel == ASEL_PC) ? pc : rs1;
    endfunction

    function automatic logic [XLEN-1:0] sel_b(input logic [1:0] sel,
                                               input logic [XLEN-1:0] rs2,
                                               input logic [XLEN-1:0] imm);
        logic [XLEN-1:0] b;
        unique case (sel)
            BSEL_RS2: b = rs2;
            BSEL_IMM: b = imm;
            BSEL_4:   b = XLEN'(4);
            default:  b = '0;
        endcase
        return b;
    endfunction

`ifdef IDEX_BYPASS_EN
    // A result retiring this cycle is newer than what the register file returned.
    function automatic logic [XLEN-1:0] fwd(input logic v, input logic [4:0] wrd,
                                            input logic [4:0] rs,
                                            input logic [XLEN-1:0] wdata,
                                            input logic [XLEN-1:0] rf);
        return (v && (wrd != 5'd0) && (wrd == rs)) ? wdata : rf;
    endfunction
`endif

    logic [XLEN-1:0] rs1_p0, rs2_p0, alua_p0, alub_p0;
    logic            rd_wen_p0;
    logic [PW-1:0]   payload_p0, head_p1;
    logic            vld_p1;

    // Capture side: operands resolved before the entry is stored.
`ifdef IDEX_BYPASS_EN
    assign rs1_p0 = fwd(wb_valid, wb_rd, in_rs1, wb_data, in_rs1_data);
    assign rs2_p0 = fwd(wb_valid, wb_rd, in_rs2, wb_data, in_rs2_data);
`else
    assign rs1_p0 = in_rs1_data;
    assign rs2_p0 = in_rs2_data;
`endif

    assign alua_p0    = sel_a(in_alua_sel, rs1_p0, in_pc);
    assign alub_p0    = sel_b(in_alub_sel, rs2_p0, in_imm);
    assign rd_wen_p0  = rd_write_en(in_rd_wen, in_rd);
    assign payload_p0 = {alua_p0, alub_p0, in_aluctr, in_pc, rs2_p0, in_rd, rd_wen_p0};

    idex_skid_buf #(
        .W         (PW),
        .RESET_VAL (PAYLOAD_RESET)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_p0),
        .out_valid (vld_p1),
        .out_ready (out_ready),
        .out_data  (head_p1)
    );

    // Head entry presented to the ALU.
    assign out_valid = vld_p1;
    assign {out_alua, out_alub, out_aluctr, out_pc, out_rs2_data, out_rd, out_rd_wen} = head_p1;

endmodule
